// File: rtl/sobel_frame_sender.sv
// sobel_frame_sender: emits a 4-byte little-endian dimension header
// (width, height) followed by width*height pixel bytes pulled from an
// upstream valid/ready source, and delivers them to a valid/ready sink.
module sobel_frame_sender #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          width_in,
  input  logic [15:0]          height_in,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_PIXELS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [15:0]          width_r;
  logic [15:0]          height_r;
  logic [31:0]          total_r;
  logic [31:0]          pix_count_r;
  logic [1:0]           hdr_idx_r;
  logic [DATA_BITS-1:0] data_out_r;
  logic                 valid_out_r;
  logic                 busy_r;
  logic                 frame_done_r;

  logic                 xfer_s;
  logic                 accept_s;
  logic                 ready_in_s;
  logic                 dims_nz_s;
  logic [7:0]           hdr_byte_nx_s;

  assign xfer_s    = valid_out_r && ready_out;
  assign accept_s  = valid_in && ready_in_s;
  assign dims_nz_s = (width_r != 16'd0) && (height_r != 16'd0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_HDR;
        else       state_nx_s = ST_IDLE;
      end
      ST_HDR: begin
        if (xfer_s && (hdr_idx_r == 2'd3)) begin
          if (dims_nz_s) state_nx_s = ST_PIXELS;
          else           state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_HDR;
        end
      end
      ST_PIXELS: begin
        // pix_count==total means no further accept is possible; leave once the held byte goes.
        if (xfer_s && !accept_s && (pix_count_r == total_r)) state_nx_s = ST_DONE;
        else                                               state_nx_s = ST_PIXELS;
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode: upstream ready and the next header byte to load
  always_comb begin
    ready_in_s    = 1'b0;
    hdr_byte_nx_s = 8'h00;
    case (state_r)
      // Opening ready_in while header byte 3 leaves removes the bubble before pixel 0.
      ST_HDR:    ready_in_s = (hdr_idx_r == 2'd3) && xfer_s && dims_nz_s;
      ST_PIXELS: ready_in_s = (pix_count_r < total_r) && (!valid_out_r || ready_out);
      default:   ready_in_s = 1'b0;
    endcase
    case (hdr_idx_r)
      2'd0:    hdr_byte_nx_s = width_r[15:8];
      2'd1:    hdr_byte_nx_s = height_r[7:0];
      2'd2:    hdr_byte_nx_s = height_r[15:8];
      default: hdr_byte_nx_s = 8'h00;
    endcase
  end

  // Datapath: dimension capture, output byte register, counters, status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_r      <= 16'd0;
      height_r     <= 16'd0;
      total_r      <= 32'd0;
      pix_count_r  <= 32'd0;
      hdr_idx_r    <= 2'd0;
      data_out_r   <= {DATA_BITS{1'b0}};
      valid_out_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      busy_r       <= (state_nx_s == ST_HDR) || (state_nx_s == ST_PIXELS);
      frame_done_r <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            width_r     <= width_in;
            height_r    <= height_in;
            total_r     <= 32'(width_in) * 32'(height_in);
            pix_count_r <= 32'd0;
            hdr_idx_r   <= 2'd0;
            data_out_r  <= DATA_BITS'(width_in[7:0]);
            valid_out_r <= 1'b1;
          end
        end
        ST_HDR: begin
          if (xfer_s) begin
            hdr_idx_r <= hdr_idx_r + 2'd1;
            if (hdr_idx_r != 2'd3) begin
              data_out_r <= DATA_BITS'(hdr_byte_nx_s);
            end else if (accept_s) begin
              data_out_r  <= data_in;
              pix_count_r <= pix_count_r + 32'd1;
            end else begin
              valid_out_r <= 1'b0;
            end
          end
        end
        ST_PIXELS: begin
          if (accept_s) begin
            data_out_r  <= data_in;
            valid_out_r <= 1'b1;
            pix_count_r <= pix_count_r + 32'd1;
          end else if (xfer_s) begin
            valid_out_r <= 1'b0;
          end
        end
        ST_DONE:  valid_out_r <= 1'b0;
        default:  valid_out_r <= 1'b0;
      endcase
    end
  end

  assign ready_in   = ready_in_s;
  assign data_out   = data_out_r;
  assign valid_out  = valid_out_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule
